// File: rtl/cd_dsp_pkg.sv
// cd_dsp_pkg: shared CD-DSP sample type, channel ids and channel-index width helper
package cd_dsp_pkg;
    localparam int SAMPLE_W = 16;
    typedef logic [SAMPLE_W-1:0] sample_t;
    localparam int CH_LEFT  = 0;
    localparam int CH_RIGHT = 1;
    function automatic int ch_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction
endpackage

// File: rtl/tap_line_channel.sv
// tap_line_channel: one DEPTH-word shift line with fill counter and primed flag
module tap_line_channel
    import cd_dsp_pkg::*;
#(
    parameter int WIDTH = SAMPLE_W,
    parameter int DEPTH = 33
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        shift,
    input  logic                        clear,
    input  logic [WIDTH-1:0]            d,
    output logic [DEPTH-1:0][WIDTH-1:0] q,
    output logic                        primed
);
    localparam int CNTW = $clog2(DEPTH + 1);
    localparam logic [CNTW-1:0] FULL = CNTW'(DEPTH);
    logic [CNTW-1:0] cnt;
    // newest sample enters at the top tap; counter saturates once a full window is held
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            q      <= '0;
            cnt    <= '0;
            primed <= 1'b0;
        end else if (clear) begin
            q      <= '0;
            cnt    <= '0;
            primed <= 1'b0;
        end else if (shift) begin
            q      <= {d, q[DEPTH-1:1]};
            cnt    <= (cnt == FULL) ? cnt : cnt + 1'b1;
            primed <= primed | (cnt == FULL - 1'b1);
        end
    end
endmodule

// File: rtl/multichannel_tap_line.sv
// multichannel_tap_line: interleaved per-channel tap delay lines; optional FLUSH via MULTICHANNEL_TAP_LINE_FLUSH_EN
module multichannel_tap_line
    import cd_dsp_pkg::*;
#(
    parameter int WIDTH    = SAMPLE_W,
    parameter int DEPTH    = 33,
    parameter int CHANNELS = 2,
    localparam int CW      = ch_width(CHANNELS)
) (
    input  logic                                      CLK,
    input  logic                                      RST,
`ifdef MULTICHANNEL_TAP_LINE_FLUSH_EN
    input  logic                                      FLUSH,
`endif
    input  logic [WIDTH-1:0]                          D,
    input  logic                                      D_VALID,
    input  logic [CW-1:0]                             D_CH,
    output logic [CHANNELS-1:0][DEPTH-1:0][WIDTH-1:0] Q,
    output logic                                      Q_VALID,
    output logic [CW-1:0]                             Q_CH,
    output logic [CHANNELS-1:0]                       PRIMED
);
    localparam logic [CW:0] NCH = (CW + 1)'(CHANNELS);
    logic flush;
    logic accept;
`ifdef MULTICHANNEL_TAP_LINE_FLUSH_EN
    assign flush = FLUSH;
`else
    assign flush = 1'b0;
`endif
    assign accept = D_VALID && ({1'b0, D_CH} < NCH) && !flush;
    // Q_VALID/Q_CH accompany the cycle in which the updated line is visible
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Q_VALID <= 1'b0;
            Q_CH    <= '0;
        end else begin
            Q_VALID <= accept;
            Q_CH    <= D_CH;
        end
    end
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        tap_line_channel #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_line (
            .CLK    (CLK),
            .RST    (RST),
            .shift  (accept && (D_CH == CW'(c))),
            .clear  (flush),
            .d      (D),
            .q      (Q[c]),
            .primed (PRIMED[c])
        );
    end
endmodule

// File: tb/tb_multichannel_tap_line.sv
// tb_multichannel_tap_line: table-driven directed bench for multichannel_tap_line
module tb_multichannel_tap_line;
    localparam int W  = 16;
    localparam int DP = 33;
    localparam int NC = 3;
    localparam int CW = 2;

    logic                         CLK = 1'b0;
    logic                         RST = 1'b1;
    logic                         D_VALID = 1'b0;
    logic [W-1:0]                 D = '0;
    logic [CW-1:0]                D_CH = '0;
`ifdef MULTICHANNEL_TAP_LINE_FLUSH_EN
    logic                         FLUSH = 1'b0;
`endif
    logic [NC-1:0][DP-1:0][W-1:0] Q;
    logic                         Q_VALID;
    logic [CW-1:0]                Q_CH;
    logic [NC-1:0]                PRIMED;

    int nvec = 0;
    int nfail = 0;

    always #5 CLK = ~CLK;

    multichannel_tap_line #(.WIDTH(W), .DEPTH(DP), .CHANNELS(NC)) dut (
        .CLK     (CLK),
        .RST     (RST),
`ifdef MULTICHANNEL_TAP_LINE_FLUSH_EN
        .FLUSH   (FLUSH),
`endif
        .D       (D),
        .D_VALID (D_VALID),
        .D_CH    (D_CH),
        .Q       (Q),
        .Q_VALID (Q_VALID),
        .Q_CH    (Q_CH),
        .PRIMED  (PRIMED)
    );

    typedef struct {
        logic        v;
        logic [1:0]  ch;
        logic [15:0] d;
        int          line;
        logic        qv;
        logic [1:0]  qch;
        logic [2:0]  pr;
        logic [15:0] nw;
        logic [15:0] pv;
        logic [15:0] od;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(input logic v, input logic [1:0] ch, input logic [15:0] d,
                                input int line, input logic qv, input logic [1:0] qch,
                                input logic [2:0] pr, input logic [15:0] nw,
                                input logic [15:0] pv, input logic [15:0] od);
        vec_t t;
        t.v = v; t.ch = ch; t.d = d; t.line = line; t.qv = qv; t.qch = qch;
        t.pr = pr; t.nw = nw; t.pv = pv; t.od = od;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input logic v, input logic [1:0] ch, input logic [15:0] d);
        @(negedge CLK);
        D_VALID = v;
        D_CH    = ch;
        D       = d;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // reset held while the strobe toggles
        for (int i = 0; i < 4; i++) begin
            apply(i[0], 2'd0, 16'hAAAA);
            chk("rst_qvalid", {31'b0, Q_VALID}, 32'd0);
            chk("rst_primed", {29'b0, PRIMED}, 32'd0);
            chk("rst_qzero", {31'b0, |Q}, 32'd0);
            chk("rst_qch", {30'b0, Q_CH}, 32'd0);
        end
        @(negedge CLK);
        RST = 1'b0;
        D_VALID = 1'b0;

        // fill channel 0 with 1..33
        for (int k = 1; k <= 33; k++)
            tv.push_back(mk(1'b1, 2'd0, 16'(k), 0, 1'b1, 2'd0, (k == 33) ? 3'b001 : 3'b000,
                            16'(k), 16'(k - 1), (k == 33) ? 16'd1 : 16'd0));
        tv.push_back(mk(1'b0, 2'd0, 16'h0, 0, 1'b0, 2'd0, 3'b001, 16'd33, 16'd32, 16'd1));
        // interleave ch0/ch1
        for (int k = 0; k < 40; k++) begin
            tv.push_back(mk(1'b1, 2'd0, 16'(16'h1000 + k), 0, 1'b1, 2'd0,
                            {1'b0, k >= 33, 1'b1}, 16'(16'h1000 + k),
                            (k > 0) ? 16'(16'h1000 + k - 1) : 16'd33,
                            (k + 1 < 33) ? 16'(k + 2) : 16'(16'h1000 + k + 1 - 33)));
            tv.push_back(mk(1'b1, 2'd1, 16'(16'h2000 + k), 1, 1'b1, 2'd1,
                            {1'b0, k >= 32, 1'b1}, 16'(16'h2000 + k),
                            (k > 0) ? 16'(16'h2000 + k - 1) : 16'd0,
                            (k >= 32) ? 16'(16'h2000 + k - 32) : 16'd0));
        end
        // out-of-range channel is dropped
        tv.push_back(mk(1'b1, 2'd3, 16'hBEEF, 0, 1'b0, 2'd0, 3'b011,
                        16'h1027, 16'h1026, 16'h1007));

        foreach (tv[i]) begin
            apply(tv[i].v, tv[i].ch, tv[i].d);
            chk($sformatf("v%0d_qvalid", i), {31'b0, Q_VALID}, {31'b0, tv[i].qv});
            if (tv[i].qv)
                chk($sformatf("v%0d_qch", i), {30'b0, Q_CH}, {30'b0, tv[i].qch});
            chk($sformatf("v%0d_primed", i), {29'b0, PRIMED}, {29'b0, tv[i].pr});
            chk($sformatf("v%0d_newest", i), {16'b0, Q[tv[i].line][DP-1]}, {16'b0, tv[i].nw});
            chk($sformatf("v%0d_prev", i), {16'b0, Q[tv[i].line][DP-2]}, {16'b0, tv[i].pv});
            chk($sformatf("v%0d_oldest", i), {16'b0, Q[tv[i].line][0]}, {16'b0, tv[i].od});
            if (i == 32) begin
                chk("fill_ch1_zero", {31'b0, |Q[1]}, 32'd0);
                chk("fill_ch2_zero", {31'b0, |Q[2]}, 32'd0);
            end
        end
        chk("oor_ch1_newest", {16'b0, Q[1][DP-1]}, 32'h2027);
        chk("oor_ch2_zero", {31'b0, |Q[2]}, 32'd0);

        // mid-stream asynchronous reset
        @(negedge CLK);
        RST = 1'b1;
        D_VALID = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 20; i++) apply(1'b1, 2'd0, 16'(16'h300 + i));
        chk("mid_pre_primed", {29'b0, PRIMED}, 32'd0);
        chk("mid_pre_newest", {16'b0, Q[0][DP-1]}, 32'h313);
        chk("mid_pre_qvalid", {31'b0, Q_VALID}, 32'd1);
        #2;
        RST = 1'b1;
        D_VALID = 1'b0;
        #1;
        chk("mid_rst_qzero", {31'b0, |Q}, 32'd0);
        chk("mid_rst_primed", {29'b0, PRIMED}, 32'd0);
        chk("mid_rst_qvalid", {31'b0, Q_VALID}, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 1; i <= 33; i++) begin
            apply(1'b1, 2'd0, 16'(i));
            chk($sformatf("refill%0d_primed", i), {29'b0, PRIMED}, (i == 33) ? 32'd1 : 32'd0);
        end
        chk("refill_oldest", {16'b0, Q[0][0]}, 32'd1);

`ifdef MULTICHANNEL_TAP_LINE_FLUSH_EN
        @(negedge CLK);
        FLUSH = 1'b1;
        D_VALID = 1'b1;
        D_CH = 2'd0;
        D = 16'h5555;
        @(posedge CLK);
        #1;
        chk("flush_qzero", {31'b0, |Q}, 32'd0);
        chk("flush_primed", {29'b0, PRIMED}, 32'd0);
        chk("flush_qvalid", {31'b0, Q_VALID}, 32'd0);
        @(negedge CLK);
        FLUSH = 1'b0;
        D_VALID = 1'b0;
        apply(1'b1, 2'd0, 16'd7);
        chk("post_flush_newest", {16'b0, Q[0][DP-1]}, 32'd7);
        chk("post_flush_prev", {16'b0, Q[0][DP-2]}, 32'd0);
        chk("post_flush_primed", {29'b0, PRIMED}, 32'd0);
        chk("post_flush_qvalid", {31'b0, Q_VALID}, 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule

// File: doc/multichannel_tap_line.md
# multichannel_tap_line

Parametrised multichannel tap delay line for the CD-DSP filter datapath. It accepts an interleaved, valid-qualified sample stream and keeps one DEPTH-word shift line per channel. Every tap of every channel is presented in parallel for the downstream FIR MAC. Per-channel fill tracking tells the MAC when a line holds a full window of real samples.

## Interface
- WIDTH, 16: sample word width in bits.
- DEPTH, 33: taps per channel; must be ≥ 2.
- CHANNELS, 2: number of independent lines; must be ≥ 1.
- CLK  input  1  sole clock; all state updates on rising edge.
- RST  input  1  asynchronous, active-high reset.
- D  input  WIDTH  incoming sample.
- D_VALID  input  1  sample strobe; one sample per asserted cycle.
- D_CH  input  CW  target channel, where CW = max(1, $clog2(CHANNELS)).
- Q  output  [CHANNELS][DEPTH][WIDTH]  all taps; Q[c][DEPTH-1] is newest, Q[c][0] is oldest.
- Q_VALID  output  1  one-cycle pulse: a line has just shifted.
- Q_CH  output  CW  channel that shifted, valid while Q_VALID is high.
- PRIMED  output  CHANNELS  bit c is high once channel c has received ≥ DEPTH samples since reset or flush.

## Operation
- On an edge with D_VALID=1 and D_CH < CHANNELS:
  - Q[D_CH][DEPTH-1] <= D.
  - Q[D_CH][i] <= Q[D_CH][i+1] for i = 0..DEPTH-2.
  - All other channels hold.
- D_VALID=1 with D_CH ≥ CHANNELS: sample is dropped, no state changes, Q_VALID stays low.
- No backpressure. D_VALID may be high every cycle, and consecutive samples may target the same or different channels.
- Fill counter per channel:
  - Width $clog2(DEPTH+1).
  - Increments on each accepted sample for that channel and saturates at DEPTH.
  - PRIMED[c] = (count[c] == DEPTH), driven from a register, not decoded combinationally from D.
- Q_VALID and Q_CH are registered copies of "sample accepted" and D_CH.
- Reset values: Q all zero, counters 0, PRIMED all 0, Q_VALID 0, Q_CH 0.
- Reset asserted mid-stream clears everything immediately. The first valid sample after reset deasserts is accepted normally, and counting restarts from 0.

## Timing
- Latency is 1 cycle. A sample strobed at edge N appears in Q[ch][DEPTH-1] after edge N.
- Q_VALID/Q_CH are high for exactly the cycle following edge N, coincident with the updated Q.
- PRIMED[c] rises in the same cycle as the Q_VALID pulse for the DEPTH-th accepted sample of channel c. It stays high, including through later samples, until reset or flush.
- A sample accepted at edge N+1 is shifted into the line that includes the sample from edge N; there are no bubbles.
- RST deassertion needs no synchronisation inside this block; release is synchronised upstream.

## Configuration
- Macro: MULTICHANNEL_TAP_LINE_FLUSH_EN.
- Defined:
  - Adds input port FLUSH (1 bit).
  - FLUSH=1 at an edge zeroes all taps, counters and PRIMED, and forces Q_VALID to 0 for the next cycle.
  - FLUSH overrides a simultaneous D_VALID; that sample is discarded.
- Undefined: FLUSH port is absent; only RST clears state.

## Structure
- Shared package cd_dsp_pkg provides:
  - typedef sample_t (logic [WIDTH-1:0] at default width 16).
  - Constants CH_LEFT=0 and CH_RIGHT=1.
  - Helper function for CW = max(1, $clog2(CHANNELS)).
- Sub-module tap_line_channel:
  - One DEPTH×WIDTH shift line with shift-enable, clear (flush), fill counter and primed flag.
  - Instantiated CHANNELS times in a generate loop.
- Top level holds channel decode, Q_VALID/Q_CH registers and the flush fan-out.

## Test plan
- Reset: drive RST=1 with D_VALID toggling -> Q all zero, PRIMED=0, Q_VALID=0 throughout.
- Fill: 33 samples 1..33 to channel 0, D_VALID every cycle -> after the 33rd, Q[0][32]=33, Q[0][0]=1, PRIMED=2'b01, and Q[1] all zero.
- Interleave: alternate ch0=0x1000+k and ch1=0x2000+k, k=0..39 -> each line holds only its own samples in order, both PRIMED bits set, Q_CH alternates 0/1.
- Out of range: CHANNELS=3, D_CH=3 with D=0xBEEF -> no Q change, Q_VALID stays low.
- Mid-stream reset: assert RST after 20 samples to ch0 -> immediate clear, PRIMED=0; 33 fresh samples are then needed before PRIMED[0]=1.
- Flush (macro defined): FLUSH and D_VALID together after priming -> all taps zero, PRIMED=0, no Q_VALID, sample discarded.
